// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS checker that locks to the sampled stream and counts bit errors.
// Define PRBS_CHK_AUTO_INV_EN to also lock to an inverted stream and report it on the inverted port.
module prbs_checker #(
  parameter int LFSR_LEN   = 7,
  parameter int TAP        = 6,
  parameter int CNT_W      = 16,
  parameter int LOCK_CNT   = 32,
  parameter int WINDOW     = 64,
  parameter int UNLOCK_ERR = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHK_AUTO_INV_EN
  ,
  output logic             inverted
`endif
);
  localparam int SW = $clog2(LFSR_LEN + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW);
  localparam int EW = $clog2(UNLOCK_ERR + 1);
  typedef enum logic [1:0] {SEED, VERIFY, LOCK} state_t;
  state_t state;
  logic [LFSR_LEN-1:0] sr;
  logic [SW-1:0] seed_cnt;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_bits;
  logic [EW-1:0] win_err;
  logic inv, pred, mism, x, err, mis_idle, win_wrap;
  assign pred = sr[LFSR_LEN-1] ^ sr[TAP-1];
  assign mism = (din ^ inv) != pred;
  // once locked the register free-runs on its own prediction, so a line error is counted once
  assign x = (state == LOCK) ? pred ^ inv : din;
  assign err = din_valid && state == LOCK && mism;
  assign win_wrap = win_bits == WW'(WINDOW - 1);
`ifdef PRBS_CHK_AUTO_INV_EN
  logic [MW-1:0] mis_cnt;
  assign inverted = inv;
  assign mis_idle = mis_cnt == '0;
`else
  assign inv = 1'b0;
  assign mis_idle = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
      sr <= '0;
      seed_cnt <= '0;
      match_cnt <= '0;
      win_bits <= '0;
      win_err <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
`ifdef PRBS_CHK_AUTO_INV_EN
      inv <= 1'b0;
      mis_cnt <= '0;
`endif
    end else begin
      err_pulse <= err;
      if (clr_cnt) err_count <= {{(CNT_W-1){1'b0}}, err};
      else if (err && !(&err_count)) err_count <= err_count + 1'b1;
      if (din_valid) begin
        sr <= {sr[LFSR_LEN-2:0], x};
        case (state)
          SEED: begin
            seed_cnt <= seed_cnt + 1'b1;
`ifdef PRBS_CHK_AUTO_INV_EN
            inv <= 1'b0;
            mis_cnt <= '0;
`endif
            if (seed_cnt == SW'(LFSR_LEN - 1)) begin
              state <= VERIFY;
              match_cnt <= '0;
            end
          end
          VERIFY: begin
            // an all-zero register would "match" a dead line forever, so it never locks
            if (!mism && mis_idle) begin
              if (match_cnt != MW'(LOCK_CNT - 1)) match_cnt <= match_cnt + 1'b1;
              else if (sr != '0) begin
                state <= LOCK;
                locked <= 1'b1;
                win_bits <= '0;
                win_err <= '0;
              end
            end
`ifdef PRBS_CHK_AUTO_INV_EN
            else if (mism && match_cnt == '0) begin
              if (mis_cnt != MW'(LOCK_CNT - 1)) mis_cnt <= mis_cnt + 1'b1;
              else if (sr != '0) begin
                state <= LOCK;
                locked <= 1'b1;
                inv <= 1'b1;
                win_bits <= '0;
                win_err <= '0;
              end
            end
`endif
            else begin
              state <= SEED;
              seed_cnt <= '0;
            end
          end
          LOCK: begin
            win_bits <= win_wrap ? '0 : win_bits + 1'b1;
            if (mism && win_err == EW'(UNLOCK_ERR - 1)) begin
              state <= SEED;
              locked <= 1'b0;
              seed_cnt <= '0;
            end else win_err <= win_wrap ? '0 : win_err + EW'(mism);
          end
          default: state <= SEED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed table-driven bench for prbs_checker (CNT_W=4 so saturation is reachable).
module tb_prbs_checker;
  logic clk = 1'b0, rst, din, din_valid, clr_cnt;
  logic locked, err_pulse;
  logic [3:0] err_count;
  logic [6:0] g = 7'h7F;
  int checks = 0, fails = 0;
`ifdef PRBS_CHK_AUTO_INV_EN
  logic inverted;
`endif
  always #5 clk = ~clk;
  prbs_checker #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
`ifdef PRBS_CHK_AUTO_INV_EN
    , .inverted(inverted)
`endif
  );
  typedef struct {
    bit rst;
    int nclean;
    bit flip;
    logic exp_locked;
    logic exp_pulse;
    int exp_cnt;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic next_bit(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask
  task automatic step(input logic d, input logic v, input logic c, input logic r);
    rst = r; din = d; din_valid = v; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask
  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      step(b, 1'b1, 1'b0, 1'b0);
    end
  endtask
  task automatic send_err(input logic c);
    logic b;
    next_bit(b);
    step(~b, 1'b1, c, 1'b0);
  endtask
  initial begin
    logic b;
    tbl.push_back('{1, 38, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 1000, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 1});
    tbl.push_back('{0, 2, 0, 1, 0, 1});
    tbl.push_back('{1, 39, 0, 1, 0, 0});
    for (int k = 1; k <= 7; k++) tbl.push_back('{0, 0, 1, 1, 1, k});
    tbl.push_back('{0, 0, 1, 0, 1, 8});
    tbl.push_back('{0, 38, 0, 0, 0, 8});
    tbl.push_back('{0, 1, 0, 1, 0, 8});
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_locked", int'(locked), 0);
    chk("reset_pulse", int'(err_pulse), 0);
    chk("reset_count", int'(err_count), 0);
    foreach (tbl[i]) begin
      if (tbl[i].rst) step(1'b0, 1'b0, 1'b0, 1'b1);
      send_clean(tbl[i].nclean);
      if (tbl[i].flip) send_err(1'b0);
      chk($sformatf("vec%0d_locked", i), int'(locked), int'(tbl[i].exp_locked));
      chk($sformatf("vec%0d_pulse", i), int'(err_pulse), int'(tbl[i].exp_pulse));
      chk($sformatf("vec%0d_count", i), int'(err_count), tbl[i].exp_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      send_clean(15);
      send_err(1'b0);
      chk($sformatf("sat%0d_count", i), int'(err_count), (9 + i > 15) ? 15 : 9 + i);
      chk($sformatf("sat%0d_locked", i), int'(locked), 1);
    end
    send_err(1'b1);
    chk("clr_err_count", int'(err_count), 1);
    chk("clr_err_pulse", int'(err_pulse), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_only_count", int'(err_count), 0);
    chk("clr_only_pulse", int'(err_pulse), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("zero_locked", int'(locked), 0);
    end
    chk("zero_count", int'(err_count), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 38; i++) begin
      send_clean(1);
      step(1'($urandom), 1'b0, 1'b0, 1'b0);
    end
    chk("half_valid_pre", int'(locked), 0);
    send_clean(1);
    chk("half_valid_lock", int'(locked), 1);
    step(1'($urandom), 1'b0, 1'b0, 1'b0);
    chk("invalid_no_pulse", int'(err_pulse), 0);
    chk("invalid_no_count", int'(err_count), 0);
    send_err(1'b0);
    chk("pre_rst_count", int'(err_count), 1);
    next_bit(b);
    step(~b, 1'b1, 1'b0, 1'b1);
    chk("rst_locked", int'(locked), 0);
    chk("rst_pulse", int'(err_pulse), 0);
    chk("rst_count", int'(err_count), 0);
`ifdef PRBS_CHK_AUTO_INV_EN
    for (int i = 0; i < 139; i++) begin
      next_bit(b);
      step(~b, 1'b1, 1'b0, 1'b0);
      if (i == 38) chk("inv_locked_39", int'(locked), 1);
    end
    chk("inv_locked", int'(locked), 1);
    chk("inv_inverted", int'(inverted), 1);
    chk("inv_count", int'(err_count), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
